// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator: sync, blank, coordinates and line/frame strobes.
// Define VGA_TIMING_REG_OUT_EN to register all outputs (one CE-cycle latency, glitch-free sync).
module vga_timing_gen #(
    parameter int unsigned CW       = 10,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CE,
    output logic          HS,
    output logic          VS,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          blank,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned W1      = CW + 1;

    if (H_TOTAL > (64'd1 << CW) || V_TOTAL > (64'd1 << CW)) begin : g_bad_params
        $error("vga_timing_gen: H_TOTAL or V_TOTAL does not fit in CW bits");
    end

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    // One extra bit so a sync window ending exactly at 2**CW still compares correctly.
    localparam logic [W1-1:0] H_AE = W1'(H_ACTIVE);
    localparam logic [W1-1:0] H_SS = W1'(H_ACTIVE + H_FP);
    localparam logic [W1-1:0] H_SE = W1'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [W1-1:0] V_AE = W1'(V_ACTIVE);
    localparam logic [W1-1:0] V_SS = W1'(V_ACTIVE + V_FP);
    localparam logic [W1-1:0] V_SE = W1'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
    logic [W1-1:0] hc_x, vc_x;
    logic          hs_c, vs_c, blank_c, ls_c, fs_c;

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (CE) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
            end else begin
                hc_d = hc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    always_comb begin
        hc_x    = {1'b0, hc_q};
        vc_x    = {1'b0, vc_q};
        hs_c    = (hc_x >= H_SS && hc_x < H_SE) ? HS_POL : ~HS_POL;
        vs_c    = (vc_x >= V_SS && vc_x < V_SE) ? VS_POL : ~VS_POL;
        blank_c = (hc_x >= H_AE) || (vc_x >= V_AE);
        ls_c    = CE && (hc_q == '0);
        fs_c    = ls_c && (vc_q == '0);
    end

`ifdef VGA_TIMING_REG_OUT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            HS          <= ~HS_POL;
            VS          <= ~VS_POL;
            blank       <= 1'b1;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            // Strobes reload every clock so they stay single-CLK pulses under a sparse CE.
            line_start  <= ls_c;
            frame_start <= fs_c;
            if (CE) begin
                HS    <= hs_c;
                VS    <= vs_c;
                blank <= blank_c;
                x     <= hc_q;
                y     <= vc_q;
            end
        end
    end
`else
    always_comb begin
        HS          = hs_c;
        VS          = vs_c;
        blank       = blank_c;
        x           = hc_q;
        y           = vc_q;
        line_start  = ls_c;
        frame_start = fs_c;
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen (default build): default 640x480, a tiny 16x10 mode
// with CW at its exact limit, and an 800x600 positive-sync override.
module tb_vga_timing_gen;

    localparam int ND = 3;
    localparam int HA [ND] = '{640, 8, 800};
    localparam int HF [ND] = '{16, 2, 40};
    localparam int HW [ND] = '{96, 3, 128};
    localparam int HB [ND] = '{48, 3, 88};
    localparam int VA [ND] = '{480, 6, 600};
    localparam int VF [ND] = '{10, 1, 1};
    localparam int VW [ND] = '{2, 2, 4};
    localparam int VB [ND] = '{33, 1, 23};
    localparam bit HP [ND] = '{1'b0, 1'b0, 1'b1};
    localparam bit VP [ND] = '{1'b0, 1'b1, 1'b1};

    typedef struct packed {
        logic        hs, vs, blank, ls, fs;
        logic [15:0] x, y;
    } obs_t;

    typedef struct {
        string tag;
        int    dut;
        obs_t  e;
    } sb_t;

    logic clk = 1'b0, rst = 1'b0, rst_s = 1'b0;
    logic ce_d = 1'b0, ce_s = 1'b0, ce_o = 1'b0;
    logic hs_d, vs_d, bl_d, ls_d, fs_d, hs_s, vs_s, bl_s, ls_s, fs_s, hs_o, vs_o, bl_o, ls_o, fs_o;
    logic [9:0]  x_d, y_d;
    logic [3:0]  x_s, y_s;
    logic [10:0] x_o, y_o;

    int   hc [ND];
    int   vc [ND];
    sb_t  sbq [$];
    obs_t od, os, oo;
    int   n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_def (
        .CLK(clk), .RST(rst), .CE(ce_d), .HS(hs_d), .VS(vs_d), .x(x_d), .y(y_d),
        .blank(bl_d), .line_start(ls_d), .frame_start(fs_d)
    );

    vga_timing_gen #(
        .CW(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b1)
    ) u_small (
        .CLK(clk), .RST(rst_s), .CE(ce_s), .HS(hs_s), .VS(vs_s), .x(x_s), .y(y_s),
        .blank(bl_s), .line_start(ls_s), .frame_start(fs_s)
    );

    vga_timing_gen #(
        .CW(11), .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23), .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_ovr (
        .CLK(clk), .RST(rst), .CE(ce_o), .HS(hs_o), .VS(vs_o), .x(x_o), .y(y_o),
        .blank(bl_o), .line_start(ls_o), .frame_start(fs_o)
    );

    function automatic obs_t model(int d, bit ce);
        obs_t o;
        int   hss = HA[d] + HF[d];
        int   vss = VA[d] + VF[d];
        o.x     = 16'(hc[d]);
        o.y     = 16'(vc[d]);
        o.blank = (hc[d] >= HA[d]) || (vc[d] >= VA[d]);
        o.hs    = (hc[d] >= hss && hc[d] < hss + HW[d]) ? HP[d] : !HP[d];
        o.vs    = (vc[d] >= vss && vc[d] < vss + VW[d]) ? VP[d] : !VP[d];
        o.ls    = ce && hc[d] == 0;
        o.fs    = o.ls && vc[d] == 0;
        return o;
    endfunction

    function automatic void adv(int d, bit ce, bit r);
        int ht = HA[d] + HF[d] + HW[d] + HB[d];
        int vt = VA[d] + VF[d] + VW[d] + VB[d];
        if (r) begin
            hc[d] = 0;
            vc[d] = 0;
        end else if (ce) begin
            if (hc[d] == ht - 1) begin
                hc[d] = 0;
                vc[d] = (vc[d] == vt - 1) ? 0 : vc[d] + 1;
            end else begin
                hc[d] = hc[d] + 1;
            end
        end
    endfunction

    function automatic obs_t dut_obs(int d);
        obs_t o;
        case (d)
            0:       o = '{hs_d, vs_d, bl_d, ls_d, fs_d, 16'(x_d), 16'(y_d)};
            1:       o = '{hs_s, vs_s, bl_s, ls_s, fs_s, 16'(x_s), 16'(y_s)};
            default: o = '{hs_o, vs_o, bl_o, ls_o, fs_o, 16'(x_o), 16'(y_o)};
        endcase
        return o;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one clock of stimulus, score all three DUTs, then advance the model past the edge.
    task automatic step(input bit c0, input bit c1, input bit c2, input bit r0, input bit r1);
        bit   ce [ND];
        sb_t  s;
        obs_t got;
        ce = '{c0, c1, c2};
        ce_d = c0; ce_s = c1; ce_o = c2; rst = r0; rst_s = r1;
        for (int d = 0; d < ND; d++) begin
            s.tag = $sformatf("dut%0d_x%0d_y%0d", d, hc[d], vc[d]);
            s.dut = d;
            s.e   = model(d, ce[d]);
            sbq.push_back(s);
        end
        #1;
        while (sbq.size() > 0) begin
            s   = sbq.pop_front();
            got = dut_obs(s.dut);
            n_chk++;
            assert (got === s.e) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", s.tag, got, s.e);
            end
        end
        od = dut_obs(0);
        os = dut_obs(1);
        oo = dut_obs(2);
        for (int d = 0; d < ND; d++) adv(d, ce[d], (d == 1) ? r1 : r0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs_first = -1, hs_last = -1, hs_cnt = 0, bl_first = -1, bl_cnt = 0;
        int ls_d_per = -1, ls_o_per = -1, oh_first = -1, oh_last = -1, oh_cnt = 0;
        int fs_prev = -1, fs_per = -1, ls_cnt = 0, lpf = -1, vs_cnt = 0, ls_prev = -1, ls_per = -1;
        bit found = 1'b0;

        rst = 1'b1; rst_s = 1'b1; ce_d = 1'b1; ce_s = 1'b1; ce_o = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin hc[d] = 0; vc[d] = 0; end
        rst = 1'b0; rst_s = 1'b0;
        #1;
        check("reset_x", int'(x_d), 0);
        check("reset_y", int'(y_d), 0);
        check("reset_blank", int'(bl_d), 0);
        check("reset_hs", int'(hs_d), 1);
        check("reset_fs", int'(fs_d), 1);

        // Free run: default line 0 in full, 6 small frames, override line 0 into line 1.
        for (int i = 0; i < 1100; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            if (i < 800) begin
                if (!od.hs) begin
                    if (hs_first < 0) hs_first = i;
                    hs_last = i;
                    hs_cnt++;
                end
                if (od.blank) begin
                    if (bl_first < 0) bl_first = i;
                    bl_cnt++;
                end
            end
            if (od.ls && i > 0 && ls_d_per < 0) ls_d_per = i;
            if (oo.ls && i > 0 && ls_o_per < 0) ls_o_per = i;
            if (oo.hs && i < 1056) begin
                if (oh_first < 0) oh_first = i;
                oh_last = i;
                oh_cnt++;
            end
            if (os.fs) begin
                if (fs_prev >= 0) begin
                    fs_per = i - fs_prev;
                    lpf    = ls_cnt;
                end
                fs_prev = i;
                ls_cnt  = 0;
            end
            if (os.ls) ls_cnt++;
            if (os.vs && i < 960) vs_cnt++;
        end
        check("def_hs_first", hs_first, 656);
        check("def_hs_last", hs_last, 751);
        check("def_hs_count", hs_cnt, 96);
        check("def_blank_first", bl_first, 640);
        check("def_blank_count", bl_cnt, 160);
        check("def_line_period", ls_d_per, 800);
        check("def_y_after_line", int'(od.y), 1);
        check("ovr_line_period", ls_o_per, 1056);
        check("ovr_hs_first", oh_first, 840);
        check("ovr_hs_last", oh_last, 967);
        check("small_frame_period", fs_per, 160);
        check("small_lines_per_frame", lpf, 10);
        check("small_vs_cycles", vs_cnt, 192);

        // CE toggling on the small mode doubles every period; the others hold with CE low.
        fs_prev = -1; fs_per = -1;
        for (int i = 0; i < 640; i++) begin
            step(1'b0, (i % 2) == 0, 1'b0, 1'b0, 1'b0);
            if (os.fs) begin
                if (fs_prev >= 0) fs_per = i - fs_prev;
                fs_prev = i;
            end
            if (os.ls) begin
                if (ls_prev >= 0 && ls_per < 0) ls_per = i - ls_prev;
                ls_prev = i;
            end
        end
        check("ce_frame_period", fs_per, 320);
        check("ce_line_period", ls_per, 32);
        check("ce_hold_x", int'(od.x), 300);
        check("ce_hold_y", int'(od.y), 1);

        // Mid-frame reset on the small mode at x=5, y=4.
        for (int i = 0; i < 200 && !found; i++) begin
            if (hc[1] == 5 && vc[1] == 4) found = 1'b1;
            else step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("rst_target_reached", int'(found), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("rst_pre_x", int'(os.x), 5);
        check("rst_pre_y", int'(os.y), 4);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_post_x", int'(os.x), 0);
        check("rst_post_y", int'(os.y), 0);
        check("rst_post_fs", int'(os.fs), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
